// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE arbiter: arbitration mode enum and a safe clog2
// helper so that single-requester builds still get a one-bit id.
package bp_cce_pkg;

   typedef enum logic {
      e_arb_fixed = 1'b0,
      e_arb_rr    = 1'b1
   } bp_cce_arb_mode_e;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_cce_arb_rr_if.sv
// Requester-side and downstream-side signals of the CCE arbiter. The slave
// modport is the arbiter's view; master is the view of whatever drives it.
interface bp_cce_arb_rr_if
   import bp_cce_pkg::*;
#(
   parameter int num_req_p    = 2,
   parameter int data_width_p = 64
);
   localparam int id_width_lp = safe_clog2(num_req_p);

   logic [num_req_p-1:0]              req_v_i;
   logic [num_req_p*data_width_p-1:0] req_data_i;
   logic [num_req_p-1:0]              req_lock_i;
   logic [num_req_p-1:0]              req_yumi_o;
   logic                              v_o;
   logic [data_width_p-1:0]           data_o;
   logic [id_width_lp-1:0]            grant_id_o;
   logic                              ready_i;

   modport slave (
      input  req_v_i, req_data_i, req_lock_i, ready_i,
      output req_yumi_o, v_o, data_o, grant_id_o
   );

   modport master (
      output req_v_i, req_data_i, req_lock_i, ready_i,
      input  req_yumi_o, v_o, data_o, grant_id_o
   );

endinterface

// File: rtl/bp_cce_arb_pick.sv
// Purely combinational pick: scans the request vector from a start index
// (wrapping) or from index 0, returning a one-hot grant and its encoded id.
module bp_cce_arb_pick
   import bp_cce_pkg::*;
#(
   parameter int num_req_p   = 2,
   parameter int id_width_lp = 1
) (
   input  logic [num_req_p-1:0]   req_i,
   input  logic [id_width_lp-1:0] start_i,
   input  bp_cce_arb_mode_e       mode_i,
   output logic [num_req_p-1:0]   grant_o,
   output logic [id_width_lp-1:0] id_o,
   output logic                   v_o
);

   int                     idx;
   logic [id_width_lp-1:0] sel;

   // First requester found in scan order wins; later hits are ignored.
   always_comb begin
      grant_o = '0;
      id_o    = '0;
      v_o     = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int i = 0; i < num_req_p; i++) begin
         idx = (mode_i == e_arb_rr) ? int'(start_i) + i : i;
         if (idx >= num_req_p) idx = idx - num_req_p;
         sel = id_width_lp'(idx);
         if (!v_o && req_i[sel]) begin
            grant_o[sel] = 1'b1;
            id_o         = sel;
            v_o          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bp_cce_arb_rr.sv
// CCE request arbiter: round-robin or fixed priority with optional grant
// locking, feeding a single registered output stage.
module bp_cce_arb_rr
   import bp_cce_pkg::*;
#(
   parameter int num_req_p    = 2,
   parameter int data_width_p = 64,
   parameter int rr_p         = 1
) (
   input logic            clk_i,
   input logic            reset_i,
   bp_cce_arb_rr_if.slave arb_if
);

   localparam int id_width_lp = safe_clog2(num_req_p);
   localparam bp_cce_arb_mode_e mode_lp = (rr_p != 0) ? e_arb_rr : e_arb_fixed;

   logic                    v_q, v_d;
   logic [data_width_p-1:0] data_q, data_d;
   logic [id_width_lp-1:0]  gid_q, gid_d;
   logic [id_width_lp-1:0]  ptr_q, ptr_d;
   logic                    lock_q, lock_d;
   logic [id_width_lp-1:0]  owner_q, owner_d;

   logic                    free;
   logic                    accept;
   logic [num_req_p-1:0]    ownerMask;
   logic [num_req_p-1:0]    eligible;
   logic [num_req_p-1:0]    grant;
   logic [id_width_lp-1:0]  pickId;
   logic                    pickV;
   logic [id_width_lp-1:0]  start;
   logic [data_width_p-1:0] dataMux;
   int                      nxt;

   assign free   = ~v_q | arb_if.ready_i;
   assign start  = (mode_lp == e_arb_rr) ? ptr_q : '0;
   assign accept = free & pickV & ~reset_i;

   // While locked only the owner may win; otherwise everyone is eligible.
   always_comb begin
      ownerMask = '0;
      for (int i = 0; i < num_req_p; i++) begin
         ownerMask[i] = !lock_q || (owner_q == id_width_lp'(i));
      end
   end

   assign eligible = arb_if.req_v_i & ownerMask;

   bp_cce_arb_pick #(
      .num_req_p   (num_req_p),
      .id_width_lp (id_width_lp)
   ) pick (
      .req_i   (eligible),
      .start_i (start),
      .mode_i  (mode_lp),
      .grant_o (grant),
      .id_o    (pickId),
      .v_o     (pickV)
   );

   always_comb begin
      dataMux = '0;
      for (int i = 0; i < num_req_p; i++) begin
         dataMux = dataMux |
            (arb_if.req_data_i[i*data_width_p +: data_width_p] & {data_width_p{grant[i]}});
      end
   end

   // Output stage loads on accept, drains when free, otherwise holds.
   always_comb begin
      v_d     = free ? pickV : v_q;
      data_d  = data_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      owner_d = owner_q;
      nxt     = 0;
      if (accept) begin
         data_d = dataMux;
         gid_d  = pickId;
         lock_d = arb_if.req_lock_i[pickId];
         if (arb_if.req_lock_i[pickId]) owner_d = pickId;
         if (mode_lp == e_arb_rr) begin
            nxt = int'(pickId) + 1;
            if (nxt >= num_req_p) nxt = 0;
            ptr_d = id_width_lp'(nxt);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q     <= 1'b0;
         data_q  <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         lock_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         v_q     <= v_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         owner_q <= owner_d;
      end
   end

   assign arb_if.req_yumi_o = accept ? grant : '0;
   assign arb_if.v_o        = v_q;
   assign arb_if.data_o     = data_q;
   assign arb_if.grant_id_o = gid_q;

endmodule

// File: tb/tb_bp_cce_arb_rr.sv
// Directed bench for bp_cce_arb_rr covering round-robin, fixed priority,
// locking, backpressure, reset and an 8-way wrap, plus per-cycle grant sanity.
module tb_bp_cce_arb_rr;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   bp_cce_arb_rr_if #(.num_req_p(2), .data_width_p(64)) if2 ();
   bp_cce_arb_rr_if #(.num_req_p(2), .data_width_p(16)) ifF ();
   bp_cce_arb_rr_if #(.num_req_p(3), .data_width_p(16)) if3 ();
   bp_cce_arb_rr_if #(.num_req_p(8), .data_width_p(16)) if8 ();

   bp_cce_arb_rr #(.num_req_p(2), .data_width_p(64), .rr_p(1)) dut2 (.clk_i(clk), .reset_i(rst), .arb_if(if2));
   bp_cce_arb_rr #(.num_req_p(2), .data_width_p(16), .rr_p(0)) dutF (.clk_i(clk), .reset_i(rst), .arb_if(ifF));
   bp_cce_arb_rr #(.num_req_p(3), .data_width_p(16), .rr_p(1)) dut3 (.clk_i(clk), .reset_i(rst), .arb_if(if3));
   bp_cce_arb_rr #(.num_req_p(8), .data_width_p(16), .rr_p(1)) dut8 (.clk_i(clk), .reset_i(rst), .arb_if(if8));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Grants must be one-hot-or-zero and only to requesters that are valid.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($onehot0(if2.req_yumi_o) && ((if2.req_yumi_o & ~if2.req_v_i) == '0)) passes++;
         else $display("[TB] FAIL yumi_sanity2 got yumi=%b v=%b", if2.req_yumi_o, if2.req_v_i);
         checks++;
         if ($onehot0(ifF.req_yumi_o) && ((ifF.req_yumi_o & ~ifF.req_v_i) == '0)) passes++;
         else $display("[TB] FAIL yumi_sanityF got yumi=%b v=%b", ifF.req_yumi_o, ifF.req_v_i);
         checks++;
         if ($onehot0(if3.req_yumi_o) && ((if3.req_yumi_o & ~if3.req_v_i) == '0)) passes++;
         else $display("[TB] FAIL yumi_sanity3 got yumi=%b v=%b", if3.req_yumi_o, if3.req_v_i);
         checks++;
         if ($onehot0(if8.req_yumi_o) && ((if8.req_yumi_o & ~if8.req_v_i) == '0)) passes++;
         else $display("[TB] FAIL yumi_sanity8 got yumi=%b v=%b", if8.req_yumi_o, if8.req_v_i);
      end
   end

   task automatic test_reset;
      rst = 1'b1;
      if2.req_v_i = 2'b11; if2.ready_i = 1'b1;
      if8.req_v_i = 8'hFF; if8.ready_i = 1'b1;
      tick(); tick();
      checks++;
      if ({if2.v_o, if2.grant_id_o, if2.data_o} !== 66'd0)
         $display("[TB] FAIL reset_out got %h want 0", {if2.v_o, if2.grant_id_o, if2.data_o});
      else passes++;
      checks++;
      if (if2.req_yumi_o !== 2'b00) $display("[TB] FAIL reset_yumi2 got %b want 00", if2.req_yumi_o);
      else passes++;
      checks++;
      if (if8.req_yumi_o !== 8'h00) $display("[TB] FAIL reset_yumi8 got %h want 00", if8.req_yumi_o);
      else passes++;
      if2.req_v_i = '0; if8.req_v_i = '0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_rr_alternate;
      logic [63:0] exp;
      if2.ready_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if2.req_data_i = {64'hB000 + 64'(n), 64'hA000 + 64'(n)};
         if2.req_v_i = 2'b11;
         #1;
         checks++;
         if (if2.req_yumi_o !== 2'(1 << (n % 2)))
            $display("[TB] FAIL rr_yumi n=%0d got %b want %b", n, if2.req_yumi_o, 2'(1 << (n % 2)));
         else passes++;
         tick();
         exp = (n % 2 == 1) ? 64'hB000 + 64'(n) : 64'hA000 + 64'(n);
         checks++;
         if ({if2.v_o, if2.grant_id_o, if2.data_o} !== {1'b1, 1'(n % 2), exp})
            $display("[TB] FAIL rr_out n=%0d got %h want %h", n,
                     {if2.v_o, if2.grant_id_o, if2.data_o}, {1'b1, 1'(n % 2), exp});
         else passes++;
      end
      if2.req_v_i = 2'b00;
      tick();
      checks++;
      if (if2.v_o !== 1'b0) $display("[TB] FAIL rr_drain got %b want 0", if2.v_o);
      else passes++;
   endtask

   task automatic test_backpressure;
      if2.ready_i = 1'b1;
      if2.req_data_i = {64'h0, 64'h1111};
      if2.req_v_i = 2'b01;
      tick();
      if2.ready_i = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if2.req_v_i = 2'b11;
         if2.req_data_i = {64'hC000 + 64'(n), 64'hD000 + 64'(n)};
         #1;
         checks++;
         if (if2.req_yumi_o !== 2'b00) $display("[TB] FAIL stall_yumi n=%0d got %b want 00", n, if2.req_yumi_o);
         else passes++;
         tick();
         checks++;
         if ({if2.v_o, if2.grant_id_o, if2.data_o} !== {1'b1, 1'b0, 64'h1111})
            $display("[TB] FAIL stall_hold n=%0d got %h want %h", n,
                     {if2.v_o, if2.grant_id_o, if2.data_o}, {1'b1, 1'b0, 64'h1111});
         else passes++;
      end
      if2.req_data_i = {64'hEEEE, 64'hFFFF};
      if2.ready_i = 1'b1;
      #1;
      checks++;
      if (if2.req_yumi_o !== 2'b10) $display("[TB] FAIL release_yumi got %b want 10", if2.req_yumi_o);
      else passes++;
      tick();
      checks++;
      if ({if2.v_o, if2.grant_id_o, if2.data_o} !== {1'b1, 1'b1, 64'hEEEE})
         $display("[TB] FAIL release_out got %h want %h", {if2.v_o, if2.grant_id_o, if2.data_o}, {1'b1, 1'b1, 64'hEEEE});
      else passes++;
      if2.req_v_i = 2'b00;
      tick();
   endtask

   task automatic test_fixed_priority;
      ifF.ready_i = 1'b1;
      ifF.req_lock_i = 2'b00;
      ifF.req_data_i = {16'h2222, 16'h1111};
      for (int n = 0; n < 4; n++) begin
         ifF.req_v_i = 2'b11;
         #1;
         checks++;
         if (ifF.req_yumi_o !== 2'b01) $display("[TB] FAIL fixed_yumi n=%0d got %b want 01", n, ifF.req_yumi_o);
         else passes++;
         tick();
         checks++;
         if ({ifF.v_o, ifF.grant_id_o, ifF.data_o} !== {1'b1, 1'b0, 16'h1111})
            $display("[TB] FAIL fixed_out n=%0d got %h want %h", n, {ifF.v_o, ifF.grant_id_o, ifF.data_o}, {1'b1, 1'b0, 16'h1111});
         else passes++;
      end
      ifF.req_v_i = 2'b10;
      #1;
      checks++;
      if (ifF.req_yumi_o !== 2'b10) $display("[TB] FAIL fixed_low_yumi got %b want 10", ifF.req_yumi_o);
      else passes++;
      tick();
      checks++;
      if ({ifF.v_o, ifF.grant_id_o, ifF.data_o} !== {1'b1, 1'b1, 16'h2222})
         $display("[TB] FAIL fixed_low_out got %h want %h", {ifF.v_o, ifF.grant_id_o, ifF.data_o}, {1'b1, 1'b1, 16'h2222});
      else passes++;
      ifF.req_v_i = 2'b00;
      tick();
   endtask

   task automatic test_lock;
      logic [2:0] lockSeq [5] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
      logic [2:0] yumiSeq [5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
      logic [1:0] gidSeq  [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
      if3.ready_i = 1'b1;
      if3.req_data_i = {16'h0C02, 16'h0B01, 16'h0A00};
      if3.req_lock_i = 3'b000;
      if3.req_v_i = 3'b001;
      tick();
      for (int n = 0; n < 5; n++) begin
         if3.req_v_i = 3'b111;
         if3.req_lock_i = lockSeq[n];
         #1;
         checks++;
         if (if3.req_yumi_o !== yumiSeq[n]) $display("[TB] FAIL lock_yumi n=%0d got %b want %b", n, if3.req_yumi_o, yumiSeq[n]);
         else passes++;
         tick();
         checks++;
         if ({if3.v_o, if3.grant_id_o} !== {1'b1, gidSeq[n]})
            $display("[TB] FAIL lock_gid n=%0d got %h want %h", n, {if3.v_o, if3.grant_id_o}, {1'b1, gidSeq[n]});
         else passes++;
      end
      if3.req_v_i = 3'b010;
      if3.req_lock_i = 3'b010;
      tick();
      if3.req_v_i = 3'b101;
      if3.req_lock_i = 3'b000;
      #1;
      checks++;
      if (if3.req_yumi_o !== 3'b000) $display("[TB] FAIL lock_persist_yumi got %b want 000", if3.req_yumi_o);
      else passes++;
      tick();
      checks++;
      if (if3.v_o !== 1'b0) $display("[TB] FAIL lock_persist_v got %b want 0", if3.v_o);
      else passes++;
   endtask

   task automatic test_reset_mid_lock;
      if3.req_v_i = 3'b111;
      if3.req_lock_i = 3'b010;
      tick();
      checks++;
      if ({if3.v_o, if3.grant_id_o} !== {1'b1, 2'd1})
         $display("[TB] FAIL midlock_owner got %h want %h", {if3.v_o, if3.grant_id_o}, {1'b1, 2'd1});
      else passes++;
      rst = 1'b1;
      #1;
      checks++;
      if (if3.req_yumi_o !== 3'b000) $display("[TB] FAIL midlock_rst_yumi got %b want 000", if3.req_yumi_o);
      else passes++;
      tick();
      checks++;
      if ({if3.v_o, if3.grant_id_o, if3.data_o} !== 19'd0)
         $display("[TB] FAIL midlock_rst_out got %h want 0", {if3.v_o, if3.grant_id_o, if3.data_o});
      else passes++;
      rst = 1'b0;
      if3.req_lock_i = 3'b000;
      #1;
      checks++;
      if (if3.req_yumi_o !== 3'b001) $display("[TB] FAIL post_rst_yumi got %b want 001", if3.req_yumi_o);
      else passes++;
      tick();
      checks++;
      if ({if3.v_o, if3.grant_id_o, if3.data_o} !== {1'b1, 2'd0, 16'h0A00})
         $display("[TB] FAIL post_rst_out got %h want %h", {if3.v_o, if3.grant_id_o, if3.data_o}, {1'b1, 2'd0, 16'h0A00});
      else passes++;
      if3.req_v_i = 3'b000;
      tick();
   endtask

   task automatic test_wrap8;
      if8.ready_i = 1'b1;
      if8.req_lock_i = 8'h00;
      for (int k = 0; k < 8; k++) if8.req_data_i[k*16 +: 16] = 16'h8000 + 16'(k);
      for (int n = 0; n < 10; n++) begin
         if8.req_v_i = 8'hFF;
         #1;
         checks++;
         if (if8.req_yumi_o !== 8'(1 << (n % 8)))
            $display("[TB] FAIL wrap_yumi n=%0d got %h want %h", n, if8.req_yumi_o, 8'(1 << (n % 8)));
         else passes++;
         tick();
         checks++;
         if ({if8.v_o, if8.grant_id_o, if8.data_o} !== {1'b1, 3'(n % 8), 16'h8000 + 16'(n % 8)})
            $display("[TB] FAIL wrap_out n=%0d got %h want %h", n, {if8.v_o, if8.grant_id_o, if8.data_o},
                     {1'b1, 3'(n % 8), 16'h8000 + 16'(n % 8)});
         else passes++;
      end
      if8.req_v_i = 8'h00;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      if2.req_v_i = '0; if2.req_data_i = '0; if2.req_lock_i = '0; if2.ready_i = 1'b0;
      ifF.req_v_i = '0; ifF.req_data_i = '0; ifF.req_lock_i = '0; ifF.ready_i = 1'b0;
      if3.req_v_i = '0; if3.req_data_i = '0; if3.req_lock_i = '0; if3.ready_i = 1'b0;
      if8.req_v_i = '0; if8.req_data_i = '0; if8.req_lock_i = '0; if8.ready_i = 1'b0;
      test_reset();
      test_rr_alternate();
      test_backpressure();
      test_fixed_priority();
      test_lock();
      test_reset_mid_lock();
      test_wrap8();
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
